// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths and state encoding for the FP normalization sequencer
package fp_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int LZC_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/zeroCounter.sv
// rtl/zeroCounter.sv - leading-zero count of a 24-bit mantissa (0..24)
module zeroCounter (
  output logic [4:0]  numZeroes,
  input  logic [23:0] value
);
  // Scanning upward lets the highest set bit win.
  always_comb begin
    numZeroes = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) numZeroes = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_normalize_ctrl.sv
// rtl/fp_normalize_ctrl.sv - multi-cycle mantissa normalization with exponent adjust
module fp_normalize_ctrl #(
  parameter int MANT_W     = fp_pkg::MANT_W,
  parameter int EXP_W      = fp_pkg::EXP_W,
  parameter int SHIFT_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              is_zero,
  output logic              underflow
);
  import fp_pkg::*;

  localparam logic [LZC_W-1:0] STEP = LZC_W'(SHIFT_STEP);

  state_t             state, nstate;
  logic               sign_reg;
  logic [EXP_W-1:0]   exp_reg;
  logic [MANT_W-1:0]  mant_reg;
  logic [LZC_W-1:0]   rem;
  logic [LZC_W-1:0]   nz;
  logic [LZC_W-1:0]   shamt;
  logic [LZC_W-1:0]   step;
  logic [EXP_W-1:0]   exp_adj;
  logic               zero_c;
  logic               uf_c;

  zeroCounter u_lzc (
    .numZeroes (nz),
    .value     (mant_reg)
  );

  // Exponent is only reduced when it stays positive; otherwise shift as far as it allows.
  always_comb begin
    shamt   = '0;
    exp_adj = '0;
    zero_c  = 1'b0;
    uf_c    = 1'b0;
    if (mant_reg == '0) begin
      zero_c = 1'b1;
    end else if (exp_reg > EXP_W'(nz)) begin
      shamt   = nz;
      exp_adj = exp_reg - EXP_W'(nz);
    end else begin
      shamt = LZC_W'(exp_reg);
      uf_c  = 1'b1;
    end
  end

  assign step = (rem > STEP) ? STEP : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = ST_COUNT;
      end
      ST_COUNT: nstate = (shamt != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (rem <= STEP) nstate = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nstate = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      mant_reg  <= '0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      mant_out  <= '0;
      is_zero   <= 1'b0;
      underflow <= 1'b0;
      rem       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign_reg <= sign_in;
            exp_reg  <= exp_in;
            mant_reg <= mant_in;
          end
        end
        ST_COUNT: begin
          sign_out  <= sign_reg;
          exp_out   <= exp_adj;
          mant_out  <= mant_reg;
          is_zero   <= zero_c;
          underflow <= uf_c;
          rem       <= shamt;
        end
        ST_SHIFT: begin
          mant_out <= mant_out << step;
          rem      <= rem - step;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_normalize_ctrl.sv
// tb/tb_fp_normalize_ctrl.sv - scoreboard bench for fp_normalize_ctrl
module tb_fp_normalize_ctrl;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [23:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [23:0] mant_out;
  logic        is_zero;
  logic        underflow;

  fp_normalize_ctrl #(.SHIFT_STEP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .is_zero   (is_zero),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  xexp;
    logic [23:0] mant;
    logic        zero;
    logic        uf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    check({tag, "_sign"}, 32'(sign_out), 32'(e.sign));
    check({tag, "_exp"}, 32'(exp_out), 32'(e.xexp));
    check({tag, "_mant"}, 32'(mant_out), 32'(e.mant));
    check({tag, "_is_zero"}, 32'(is_zero), 32'(e.zero));
    check({tag, "_underflow"}, 32'(underflow), 32'(e.uf));
  endtask

  // Monitor: pop on the rising edge of out_valid, then check outputs stay put while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got out_valid=1 expected no pending result");
        end else begin
          cur = sb.pop_front();
          check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
          cmp_out("result", cur);
        end
      end else if (out_valid && prev_ov) begin
        cmp_out("held", cur);
      end
      prev_ov = out_valid;
    end
  end

  task automatic push(input logic s, input logic [7:0] xe, input logic [23:0] xm,
                      input logic xz, input logic xu, input int lat);
    exp_t t;
    t.sign = s; t.xexp = xe; t.mant = xm; t.zero = xz; t.uf = xu; t.lat = lat;
    t.acc  = cyc + 1;
    sb.push_back(t);
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                      input logic [7:0] xe, input logic [23:0] xm,
                      input logic xz, input logic xu, input int lat);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    sign_in = s; exp_in = e; mant_in = m; in_valid = 1'b1;
    push(s, xe, xm, xz, xu, lat);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign_in = 1'b0; exp_in = '0; mant_in = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    check("rst_mant", 32'(mant_out), 32'd0);
    check("rst_flags", 32'({sign_out, is_zero, underflow}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(1'b0, 8'd100, 24'h888888, 8'd100, 24'h888888, 1'b0, 1'b0, 2); wait_idle();
    send(1'b1, 8'd100, 24'h000888, 8'd88,  24'h888000, 1'b0, 1'b0, 4); wait_idle();
    send(1'b0, 8'd5,   24'h000888, 8'd0,   24'h011100, 1'b0, 1'b1, 3); wait_idle();
    send(1'b1, 8'd77,  24'h000000, 8'd0,   24'h000000, 1'b1, 1'b0, 2); wait_idle();
    send(1'b0, 8'd0,   24'h800000, 8'd0,   24'h800000, 1'b0, 1'b1, 2); wait_idle();
    send(1'b0, 8'd200, 24'h000001, 8'd177, 24'h800000, 1'b0, 1'b0, 5); wait_idle();
    send(1'b1, 8'd12,  24'h000888, 8'd0,   24'h888000, 1'b0, 1'b1, 4); wait_idle();

    // Downstream stall: result held, input side closed, stray pulses ignored.
    out_ready = 1'b0;
    send(1'b0, 8'd100, 24'h888888, 8'd100, 24'h888888, 1'b0, 1'b0, 2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      exp_in = 8'd3; mant_in = 24'h000001;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b1; sign_in = 1'b1; exp_in = 8'd5; mant_in = 24'h000888;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    push(1'b1, 8'd0, 24'h011100, 1'b0, 1'b1, 3);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

    // Reset while shifting drops the operation.
    send(1'b1, 8'd100, 24'h000888, 8'd88, 24'h888000, 1'b0, 1'b0, 4);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_exp", 32'(exp_out), 32'd0);
    check("midrst_mant", 32'(mant_out), 32'd0);
    check("midrst_flags", 32'({sign_out, is_zero, underflow}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b1, 8'd100, 24'h000888, 8'd88, 24'h888000, 1'b0, 1'b0, 4); wait_idle();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
